// File: rtl/bram_byte_reader.sv
// Streams a byte-length buffer out of a row-wide block RAM, column 0 first.
// Define BRAM_READER_CHECKSUM_EN to build the 16-bit one's-complement checksum.
module bram_byte_reader #(
    parameter int W  = 32,
    parameter int L  = 375,
    parameter int LW = $clog2(L * (W / 8) + 1),
    localparam int C  = W / 8,
    localparam int AW = $clog2(L)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic [LW-1:0] start_len,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] ram_addr,
    input  logic [W-1:0]  ram_rd_data,
    output logic [7:0]    m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_last,
    output logic [15:0]   csum
);

    localparam int IW = (C > 1) ? $clog2(C) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_LOAD,
        S_STREAM,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [W-1:0]  r_hold;
    logic [IW-1:0] r_idx;
    logic [LW-1:0] r_rem;
    logic [AW-1:0] r_addr;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_last;
    logic          r_busy;
    logic          r_done;

    logic          w_hs;
    logic          w_row_end;
    logic [AW-1:0] w_addr_nxt;

    assign w_hs       = r_valid & m_ready;
    assign w_row_end  = (r_idx == IW'(C - 1));
    assign w_addr_nxt = (r_addr == AW'(L - 1)) ? '0 : r_addr + 1'b1;

    // Next row is already addressed while the current one drains, so a
    // row boundary costs no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_hold  <= '0;
            r_idx   <= '0;
            r_rem   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        r_addr <= start_addr;
                        r_rem  <= start_len;
                        if (start_len == '0) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_PRIME;
                        end
                    end
                end
                S_PRIME: begin
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_hold  <= ram_rd_data;
                    r_data  <= ram_rd_data[7:0];
                    r_addr  <= w_addr_nxt;
                    r_idx   <= '0;
                    r_valid <= 1'b1;
                    r_last  <= (r_rem == LW'(1));
                    r_state <= S_STREAM;
                end
                S_STREAM: begin
                    if (w_hs) begin
                        if (r_last) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_rem   <= '0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_rem  <= r_rem - 1'b1;
                            r_last <= (r_rem == LW'(2));
                            if (w_row_end) begin
                                r_hold <= ram_rd_data;
                                r_data <= ram_rd_data[7:0];
                                r_addr <= w_addr_nxt;
                                r_idx  <= '0;
                            end else begin
                                r_hold <= {8'h00, r_hold[W-1:8]};
                                r_data <= r_hold[15:8];
                                r_idx  <= r_idx + 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign ram_addr = r_addr;
    assign m_data   = r_data;
    assign m_valid  = r_valid;
    assign m_last   = r_last;

`ifdef BRAM_READER_CHECKSUM_EN
    logic [15:0] r_csum;
    logic        r_odd;
    logic [15:0] w_term;
    logic [16:0] w_sum;

    // Even-position byte lands in the high half; a trailing odd byte is
    // thus implicitly padded with 0x00.
    assign w_term = r_odd ? {8'h00, r_data} : {r_data, 8'h00};
    assign w_sum  = {1'b0, r_csum} + {1'b0, w_term};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_csum <= '0;
            r_odd  <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            r_csum <= '0;
            r_odd  <= 1'b0;
        end else if (w_hs) begin
            r_csum <= w_sum[15:0] + {15'd0, w_sum[16]};
            r_odd  <= ~r_odd;
        end
    end

    assign csum = r_csum;
`else
    assign csum = 16'h0000;
`endif

endmodule
